// File: rtl/joypad_scanner_if.sv
// Signal bundle between joypad_scanner, the board pad pins and the NES core ports.
interface joypad_scanner_if #(
    parameter int NUM_PADS = 4,
    parameter int PAD_BITS = 8
);
    logic                  enable;
    logic                  fourscore_en;
    logic                  joy_strobe;
    logic                  joy_clock;
    logic [NUM_PADS-1:0]   joy_data;
    logic [4*PAD_BITS-1:0] pad_state;
    logic [3:0]            pad_present;
    logic                  scan_done;
    logic                  core_strobe;
    logic [1:0]            core_clock;
    logic [1:0]            core_data;

    modport master (
        output enable, fourscore_en, joy_data, core_strobe, core_clock,
        input  joy_strobe, joy_clock, pad_state, pad_present, scan_done, core_data
    );

    modport slave (
        input  enable, fourscore_en, joy_data, core_strobe, core_clock,
        output joy_strobe, joy_clock, pad_state, pad_present, scan_done, core_data
    );
endinterface

// File: rtl/joypad_scanner.sv
// Scans up to four serial NES/SNES pads on shared strobe/clock lines and serves
// the NES core's two controller ports in plain or Four Score multiplexed form.
module joypad_scanner #(
    parameter int NUM_PADS     = 4,
    parameter int PAD_BITS     = 8,
    parameter int PHASE_CYCLES = 128
) (
    input  logic            clock,
    input  logic            reset_n,
    joypad_scanner_if.slave bus
);
    localparam int PH_LAST = 2 * PAD_BITS + 1;
    localparam int PH_W    = $clog2(PH_LAST + 1);
    localparam int CNT_W   = $clog2(PHASE_CYCLES);
    localparam int IDX_W   = $clog2(PAD_BITS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_FINAL   = PH_W'(PH_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_READ  = 2'd2,
        ST_CLOCK = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [PH_W-1:0]          ph_r, ph_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic                     sample_s, commit_s;
    logic [IDX_W-1:0]         bit_idx_s;
    logic                     strobe_r, clk_r, done_r;
    logic [3:0][PAD_BITS-1:0] pad_word_s;
    logic [3:0]               present_s;
    logic [23:0]              s0_r, s1_r, load0_s, load1_s;
    logic [1:0]               core_clk_prev_r, fall_s;

    // Read phases are the odd phases from 3 upward, one per shifted bit.
    assign bit_idx_s = IDX_W'((ph_r - PH_W'(3)) >> 1);

    // Phase sequencing: advance on counter expiry, hold idle until enabled
    always_comb begin
        state_nxt_s = state_r;
        ph_nxt_s    = ph_r;
        cnt_nxt_s   = cnt_r;
        sample_s    = 1'b0;
        commit_s    = 1'b0;
        if (cnt_r == {CNT_W{1'b0}}) begin
            cnt_nxt_s = CNT_RELOAD;
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable) begin
                        ph_nxt_s    = PH_W'(1);
                        state_nxt_s = ST_LATCH;
                    end else begin
                        ph_nxt_s    = ph_r;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    ph_nxt_s    = ph_r + PH_W'(1);
                    state_nxt_s = (ph_r == PH_W'(1)) ? ST_LATCH : ST_READ;
                end
                ST_READ: begin
                    sample_s = 1'b1;
                    if (ph_r == PH_FINAL) begin
                        commit_s    = 1'b1;
                        ph_nxt_s    = {PH_W{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ph_nxt_s    = ph_r + PH_W'(1);
                        state_nxt_s = ST_CLOCK;
                    end
                end
                ST_CLOCK: begin
                    ph_nxt_s    = ph_r + PH_W'(1);
                    state_nxt_s = ST_READ;
                end
                default: begin
                    ph_nxt_s    = {PH_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end
    end

    // Sequencer state plus pin levels registered from the upcoming phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            ph_r     <= {PH_W{1'b0}};
            cnt_r    <= CNT_RELOAD;
            strobe_r <= 1'b0;
            clk_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ph_r     <= ph_nxt_s;
            cnt_r    <= cnt_nxt_s;
            strobe_r <= (state_nxt_s == ST_LATCH);
            clk_r    <= (state_nxt_s == ST_CLOCK);
            done_r   <= commit_s;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_pad
        if (n < NUM_PADS) begin : g_live
            logic [PAD_BITS-1:0] cap_r, raw_s, word_r;
            logic                present_r;

            // The final bit is merged straight into the committed word.
            always_comb begin
                raw_s            = cap_r;
                raw_s[bit_idx_s] = bus.joy_data[n];
            end

            // Capture shifted bits and publish the word at scan end
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cap_r     <= {PAD_BITS{1'b0}};
                    word_r    <= {PAD_BITS{1'b0}};
                    present_r <= 1'b0;
                end else begin
                    cap_r <= sample_s ? raw_s : cap_r;
                    if (commit_s) begin
                        present_r <= |raw_s;
                        word_r    <= (|raw_s) ? ~raw_s : {PAD_BITS{1'b0}};
                    end else begin
                        present_r <= present_r;
                        word_r    <= word_r;
                    end
                end
            end

            assign pad_word_s[n] = word_r;
            assign present_s[n]  = present_r;
        end else begin : g_absent
            assign pad_word_s[n] = {PAD_BITS{1'b0}};
            assign present_s[n]  = 1'b0;
        end
    end

    assign fall_s = core_clk_prev_r & ~bus.core_clock;

    // Four Score frames carry two pads followed by the port's signature byte
    always_comb begin
        if (bus.fourscore_en) begin
            load0_s = {8'h08, pad_word_s[2][7:0], pad_word_s[0][7:0]};
            load1_s = {8'h04, pad_word_s[3][7:0], pad_word_s[1][7:0]};
        end else begin
            load0_s = {16'hFFFF, pad_word_s[0][7:0]};
            load1_s = {16'hFFFF, pad_word_s[1][7:0]};
        end
    end

    // Core-side shift registers; a strobe reload beats a same-cycle shift
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_r            <= 24'h000000;
            s1_r            <= 24'h000000;
            core_clk_prev_r <= 2'b00;
        end else begin
            core_clk_prev_r <= bus.core_clock;
            if (bus.core_strobe) begin
                s0_r <= load0_s;
                s1_r <= load1_s;
            end else begin
                s0_r <= fall_s[0] ? {1'b1, s0_r[23:1]} : s0_r;
                s1_r <= fall_s[1] ? {1'b1, s1_r[23:1]} : s1_r;
            end
        end
    end

    assign bus.joy_strobe  = strobe_r;
    assign bus.joy_clock   = clk_r;
    assign bus.scan_done   = done_r;
    assign bus.pad_state   = pad_word_s;
    assign bus.pad_present = present_s;
    assign bus.core_data   = {s1_r[0], s0_r[0]};
endmodule

// File: tb/tb_joypad_scanner.sv
// Bench for joypad_scanner: behavioural pads on the pin side, protocol-level
// expectations for the committed words and the core-side serial frames.
module tb_joypad_scanner;
    localparam int PC = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    joypad_scanner_if #(.NUM_PADS(4), .PAD_BITS(8))  bus8 ();
    joypad_scanner_if #(.NUM_PADS(2), .PAD_BITS(16)) bus16 ();

    joypad_scanner #(.NUM_PADS(4), .PAD_BITS(8), .PHASE_CYCLES(PC)) dut8 (
        .clock(clock), .reset_n(reset_n), .bus(bus8));
    joypad_scanner #(.NUM_PADS(2), .PAD_BITS(16), .PHASE_CYCLES(PC)) dut16 (
        .clock(clock), .reset_n(reset_n), .bus(bus16));

    logic [7:0]  raw8  [4];
    logic [15:0] raw16 [2];
    logic [7:0]  sh8   [4];
    logic [15:0] sh16  [2];
    logic        pc8, pc16;

    // Pad model: latch while strobed, advance one button per rising shift clock.
    initial begin
        pc8 = 1'b0; pc16 = 1'b0;
        for (int n = 0; n < 4; n++) begin raw8[n] = 8'h00; sh8[n] = 8'h00; end
        for (int n = 0; n < 2; n++) begin raw16[n] = 16'h0000; sh16[n] = 16'h0000; end
        bus8.joy_data = 4'b0000; bus16.joy_data = 2'b00;
        forever begin
            @(negedge clock);
            for (int n = 0; n < 4; n++) begin
                if (bus8.joy_strobe) sh8[n] = raw8[n];
                else if (bus8.joy_clock && !pc8) sh8[n] = sh8[n] >> 1;
                bus8.joy_data[n] = sh8[n][0];
            end
            pc8 = bus8.joy_clock;
            for (int n = 0; n < 2; n++) begin
                if (bus16.joy_strobe) sh16[n] = raw16[n];
                else if (bus16.joy_clock && !pc16) sh16[n] = sh16[n] >> 1;
                bus16.joy_data[n] = sh16[n][0];
            end
            pc16 = bus16.joy_clock;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] exp8(input logic [7:0] raw);
        logic [7:0] pressed;
        for (int i = 0; i < 8; i++) pressed[i] = (raw[i] == 1'b0);
        return (raw == 8'h00) ? 8'h00 : pressed;
    endfunction

    function automatic logic [15:0] exp16(input logic [15:0] raw);
        logic [15:0] pressed;
        for (int i = 0; i < 16; i++) pressed[i] = (raw[i] == 1'b0);
        return (raw == 16'h0000) ? 16'h0000 : pressed;
    endfunction

    function automatic logic [7:0] rand8();
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 4) == 0) v = 8'h00;
        else if ($urandom_range(0, 4) == 0) v = 8'hFF;
        return v;
    endfunction

    task automatic wait_done(input bit wide, input int budget, output bit seen, output int at);
        seen = 1'b0; at = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clock);
            if ((wide ? bus16.scan_done : bus8.scan_done) == 1'b1) begin seen = 1'b1; at = cyc; end
        end
    endtask

    task automatic strobe_pulse();
        @(negedge clock); bus8.core_strobe = 1'b1;
        @(negedge clock); bus8.core_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus8.enable = 1'b0; bus8.fourscore_en = 1'b0; bus8.core_strobe = 1'b0; bus8.core_clock = 2'b00;
        bus16.enable = 1'b0; bus16.fourscore_en = 1'b0; bus16.core_strobe = 1'b0; bus16.core_clock = 2'b00;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({bus8.joy_strobe, bus8.joy_clock, bus8.scan_done, bus8.core_data} !== 5'b00000)
            $display("FAIL reset_pins8: got %b want 00000", {bus8.joy_strobe, bus8.joy_clock, bus8.scan_done, bus8.core_data});
        else n_pass++;
        n_checks++;
        if ({bus8.pad_state, bus8.pad_present} !== 36'h0)
            $display("FAIL reset_state8: got %h want 0", {bus8.pad_state, bus8.pad_present});
        else n_pass++;
        n_checks++;
        if ({bus16.pad_state, bus16.pad_present, bus16.joy_strobe, bus16.scan_done} !== 70'h0)
            $display("FAIL reset_state16: got %h want 0", {bus16.pad_state, bus16.pad_present});
        else n_pass++;
    endtask

    // Shared by the first scan and the post-abort rescan: timing from reset release.
    task automatic scan_from_release(input string tag);
        int first_strobe = -1, strobe_cnt = 0, rises = 0, falls = 0, bad_w = 0;
        int first_rise = -1, rise_at = 0, done_at = -1;
        logic prev = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            @(negedge clock);
            if (bus8.joy_strobe) begin
                strobe_cnt++;
                if (first_strobe < 0) first_strobe = cyc;
            end
            if (bus8.joy_clock && !prev) begin
                rises++; rise_at = cyc;
                if (first_rise < 0) first_rise = cyc;
            end
            if (!bus8.joy_clock && prev) begin
                falls++;
                if (cyc - rise_at != PC) bad_w++;
            end
            prev = bus8.joy_clock;
            if (bus8.scan_done) done_at = cyc;
        end
        n_checks++;
        if (done_at !== 72) $display("FAIL %s_done_cycle: got %0d want 72", tag, done_at); else n_pass++;
        n_checks++;
        if (first_strobe !== PC) $display("FAIL %s_strobe_start: got %0d want %0d", tag, first_strobe, PC); else n_pass++;
        n_checks++;
        if (strobe_cnt !== 2 * PC) $display("FAIL %s_strobe_len: got %0d want %0d", tag, strobe_cnt, 2 * PC); else n_pass++;
        n_checks++;
        if (rises !== 7 || falls !== 7 || bad_w !== 0)
            $display("FAIL %s_clock_pulses: got rises %0d falls %0d badwidth %0d want 7 7 0", tag, rises, falls, bad_w);
        else n_pass++;
        n_checks++;
        if (first_rise !== 4 * PC) $display("FAIL %s_first_clock: got %0d want %0d", tag, first_rise, 4 * PC); else n_pass++;
        n_checks++;
        if (bus8.pad_state !== {exp8(raw8[3]), exp8(raw8[2]), exp8(raw8[1]), exp8(raw8[0])})
            $display("FAIL %s_state: got %h want %h", tag, bus8.pad_state,
                     {exp8(raw8[3]), exp8(raw8[2]), exp8(raw8[1]), exp8(raw8[0])});
        else n_pass++;
        n_checks++;
        if (bus8.pad_present !== {raw8[3] != 8'h00, raw8[2] != 8'h00, raw8[1] != 8'h00, raw8[0] != 8'h00})
            $display("FAIL %s_present: got %b", tag, bus8.pad_present);
        else n_pass++;
    endtask

    task automatic test_first_scan();
        raw8 = '{8'hFE, 8'h00, 8'h00, 8'h00};
        bus8.enable = 1'b1;
        scan_from_release("first");
        n_checks++;
        if (bus8.pad_state !== 32'h0000_0001 || bus8.pad_present !== 4'b0001)
            $display("FAIL first_literal: got %h/%b want 00000001/0001", bus8.pad_state, bus8.pad_present);
        else n_pass++;
    endtask

    task automatic test_random_scans();
        bit seen; int at; int last_at;
        last_at = cyc;
        for (int s = 0; s < 6; s++) begin
            for (int n = 0; n < 4; n++) raw8[n] = rand8();
            wait_done(1'b0, 200, seen, at);
            n_checks++;
            if (!seen || at - last_at != 72)
                $display("FAIL rand_period: got seen %0d period %0d want 72", seen, at - last_at);
            else n_pass++;
            last_at = at;
            n_checks++;
            if (bus8.pad_state !== {exp8(raw8[3]), exp8(raw8[2]), exp8(raw8[1]), exp8(raw8[0])})
                $display("FAIL rand_state: got %h want %h", bus8.pad_state,
                         {exp8(raw8[3]), exp8(raw8[2]), exp8(raw8[1]), exp8(raw8[0])});
            else n_pass++;
            n_checks++;
            if (bus8.pad_present !== {raw8[3] != 8'h00, raw8[2] != 8'h00, raw8[1] != 8'h00, raw8[0] != 8'h00})
                $display("FAIL rand_present: got %b raw %h %h %h %h", bus8.pad_present, raw8[3], raw8[2], raw8[1], raw8[0]);
            else n_pass++;
        end
    endtask

    task automatic test_snes();
        bit seen; int at; int first_at;
        raw16[0] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        raw16[1] = 16'hFF7F;
        bus16.enable = 1'b1;
        wait_done(1'b1, 400, seen, first_at);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (bus16.pad_state !== {32'h0, exp16(raw16[1]), exp16(raw16[0])} ||
                bus16.pad_present !== {2'b00, raw16[1] != 16'h0000, raw16[0] != 16'h0000})
                $display("FAIL snes_scan%0d: got %h/%b want %h", s, bus16.pad_state, bus16.pad_present,
                         {32'h0, exp16(raw16[1]), exp16(raw16[0])});
            else n_pass++;
            raw16[0] = 16'($urandom); raw16[1] = 16'($urandom) | 16'h0001;
            wait_done(1'b1, 400, seen, at);
            n_checks++;
            if (!seen || at - first_at != 136)
                $display("FAIL snes_period: got seen %0d period %0d want 136", seen, at - first_at);
            else n_pass++;
            first_at = at;
        end
        n_checks++;
        if (bus16.pad_state[31:16] !== exp16(raw16[1]))
            $display("FAIL snes_pad1: got %h want %h", bus16.pad_state[31:16], exp16(raw16[1]));
        else n_pass++;
        bus16.enable = 1'b0;
    endtask

    task automatic test_core_fourscore();
        bit seen; int at;
        bit q0[$]; bit q1[$];
        logic [7:0] p[4];
        logic [7:0] sig0, sig1;
        logic e0, e1;
        sig0 = 8'h08; sig1 = 8'h04;
        raw8 = '{8'hFE, 8'hFE, 8'h7F, rand8()};
        wait_done(1'b0, 200, seen, at);
        wait_done(1'b0, 200, seen, at);
        for (int n = 0; n < 4; n++) p[n] = exp8(raw8[n]);
        for (int i = 0; i < 8; i++) begin q0.push_back(p[0][i]); q1.push_back(p[1][i]); end
        for (int i = 0; i < 8; i++) begin q0.push_back(p[2][i]); q1.push_back(p[3][i]); end
        for (int i = 0; i < 8; i++) begin q0.push_back(sig0[i]); q1.push_back(sig1[i]); end
        bus8.fourscore_en = 1'b1;
        strobe_pulse();
        for (int b = 0; b < 28; b++) begin
            e0 = (b < 24) ? q0[b] : 1'b1;
            e1 = (b < 24) ? q1[b] : 1'b1;
            n_checks++;
            if (bus8.core_data[0] !== e0) $display("FAIL fs_port0 bit %0d: got %b want %b", b, bus8.core_data[0], e0);
            else n_pass++;
            n_checks++;
            if (bus8.core_data[1] !== e1) $display("FAIL fs_port1 bit %0d: got %b want %b", b, bus8.core_data[1], e1);
            else n_pass++;
            bus8.core_clock = 2'b11; @(negedge clock);
            bus8.core_clock = 2'b00; @(negedge clock);
        end
    endtask

    task automatic test_core_plain();
        bit seen; int at;
        logic [7:0] p0;
        logic e;
        bus8.fourscore_en = 1'b0;
        p0 = exp8(raw8[0]);
        strobe_pulse();
        for (int b = 0; b < 12; b++) begin
            if (b == 4) begin
                raw8[0] = raw8[0] ^ 8'h3C;
                wait_done(1'b0, 200, seen, at);
                wait_done(1'b0, 200, seen, at);
                n_checks++;
                if (bus8.pad_state[7:0] !== exp8(raw8[0]))
                    $display("FAIL plain_newstate: got %h want %h", bus8.pad_state[7:0], exp8(raw8[0]));
                else n_pass++;
            end
            e = (b < 8) ? p0[b] : 1'b1;
            n_checks++;
            if (bus8.core_data[0] !== e) $display("FAIL plain_port0 bit %0d: got %b want %b", b, bus8.core_data[0], e);
            else n_pass++;
            bus8.core_clock = 2'b01; @(negedge clock);
            bus8.core_clock = 2'b00; @(negedge clock);
        end
    endtask

    task automatic test_strobe_vs_fall();
        logic [7:0] p1;
        bus8.fourscore_en = 1'b1;
        p1 = exp8(raw8[1]);
        strobe_pulse();
        bus8.core_clock = 2'b10; @(negedge clock);
        bus8.core_clock = 2'b00; @(negedge clock);
        n_checks++;
        if (bus8.core_data[1] !== p1[1]) $display("FAIL svf_shift: got %b want %b", bus8.core_data[1], p1[1]);
        else n_pass++;
        bus8.core_clock = 2'b10; @(negedge clock);
        bus8.core_strobe = 1'b1; bus8.core_clock = 2'b00; @(negedge clock);
        bus8.core_strobe = 1'b0;
        n_checks++;
        if (bus8.core_data[1] !== p1[0]) $display("FAIL svf_reload: got %b want %b", bus8.core_data[1], p1[0]);
        else n_pass++;
        bus8.core_clock = 2'b10; @(negedge clock);
        bus8.core_clock = 2'b00; @(negedge clock);
        n_checks++;
        if (bus8.core_data[1] !== p1[1]) $display("FAIL svf_after: got %b want %b", bus8.core_data[1], p1[1]);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit seen; int at; int k; int strobes; int dones;
        logic [31:0] want;
        want = {exp8(raw8[3]), exp8(raw8[2]), exp8(raw8[1]), exp8(raw8[0])};
        k = 0;
        while (bus8.joy_strobe !== 1'b1 && k < 200) begin @(negedge clock); k++; end
        bus8.enable = 1'b0;
        wait_done(1'b0, 200, seen, at);
        n_checks++;
        if (!seen || bus8.pad_state !== want)
            $display("FAIL endrop_complete: got seen %0d state %h want 1 %h", seen, bus8.pad_state, want);
        else n_pass++;
        strobes = 0; dones = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clock);
            strobes += bus8.joy_strobe;
            dones   += bus8.scan_done;
        end
        n_checks++;
        if (strobes !== 0 || dones !== 0)
            $display("FAIL endrop_hold: got strobes %0d dones %0d want 0 0", strobes, dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int k; int s_at;
        for (int n = 0; n < 4; n++) raw8[n] = raw8[n] ^ 8'h5A;
        raw8[1] = 8'h69;
        bus8.enable = 1'b1;
        k = 0;
        while (bus8.joy_strobe !== 1'b1 && k < 200) begin @(negedge clock); k++; end
        s_at = cyc;
        k = 0;
        while (cyc < s_at + 8 * PC + 1 && k < 200) begin @(negedge clock); k++; end
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus8.joy_strobe, bus8.joy_clock, bus8.scan_done, bus8.core_data, bus8.pad_present} !== 9'h0)
            $display("FAIL rst_mid_pins: got %b want 0",
                     {bus8.joy_strobe, bus8.joy_clock, bus8.scan_done, bus8.core_data, bus8.pad_present});
        else n_pass++;
        n_checks++;
        if (bus8.pad_state !== 32'h0) $display("FAIL rst_mid_state: got %h want 0", bus8.pad_state);
        else n_pass++;
        @(negedge clock);
        scan_from_release("rescan");
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_random_scans();
        test_snes();
        test_core_fourscore();
        test_core_plain();
        test_strobe_vs_fall();
        test_enable_drop();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
